// File: rtl/mram_link_pkg.sv
// rtl/mram_link_pkg.sv - shared link widths, rw encoding and host FSM states
package mram_link_pkg;

   localparam int LINK_ADDR_W = 20;
   localparam int LINK_DATA_W = 16;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SHIFT,
      WAIT_WR,
      WAIT_RD,
      CAPTURE,
      RESP
   } link_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/mram_serial_host_if.sv
// rtl/mram_serial_host_if.sv - command/response handshake and serial link signals of the MRAM host
interface mram_serial_host_if #(
   parameter int ADDR_W = mram_link_pkg::LINK_ADDR_W,
   parameter int DATA_W = mram_link_pkg::LINK_DATA_W
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_rw;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;
   logic              link_start;
   logic              rw_sel;
   logic              addr_ser;
   logic              data_ser;
   logic              ser_data_in;

   modport master (
      output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, ser_data_in,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             link_start, rw_sel, addr_ser, data_ser
   );

   modport slave (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, ser_data_in,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             link_start, rw_sel, addr_ser, data_ser
   );
endinterface

// File: rtl/mram_link_shifter.sv
// rtl/mram_link_shifter.sv - loadable MSB-first shift register, parallel/serial in and out
module mram_link_shifter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_data_i,
   input  logic         shift_i,
   input  logic         ser_i,
   output logic         ser_o,
   output logic [W-1:0] par_o
);
   logic [W-1:0] sh_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q <= '0;
      end else if (load_i) begin
         sh_q <= load_data_i;
      end else if (shift_i) begin
         sh_q <= {sh_q[W-2:0], ser_i};
      end
   end

   assign ser_o = sh_q[W-1];
   assign par_o = sh_q;
endmodule

// File: rtl/mram_serial_host.sv
// rtl/mram_serial_host.sv - MRAM serial link initiator: serialises commands, deserialises read data
// Optional MRAM_HOST_PARITY_EN adds a trailing even-parity bit to both the shift and capture phases.
module mram_serial_host #(
   parameter int ADDR_W  = mram_link_pkg::LINK_ADDR_W,
   parameter int DATA_W  = mram_link_pkg::LINK_DATA_W,
   parameter int WR_WAIT = 4,
   parameter int RD_LAT  = 6
) (
   input logic              clk,
   input logic              rst,
   mram_serial_host_if.slave bus
);
   import mram_link_pkg::*;

   localparam int CNT_W = $clog2(max3(ADDR_W, WR_WAIT, RD_LAT) + 1);
`ifdef MRAM_HOST_PARITY_EN
   localparam int SHIFT_LEN = ADDR_W + 1;
   localparam int CAP_LEN   = DATA_W + 1;
`else
   localparam int SHIFT_LEN = ADDR_W;
   localparam int CAP_LEN   = DATA_W;
`endif

   link_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rw_q;
   logic              en_q;
   logic              accept;
   logic              shift_go;
   logic              cap_go;
   logic [DATA_W-1:0] wdata_load;
   logic              addr_bit;
   logic              wdata_bit;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] addr_par_unused;
   logic [DATA_W-1:0] wdata_par_unused;
   logic              rdata_msb_unused;

   // en_q keeps cmd_ready low while reset is held, so every output reads 0 in reset.
   assign accept     = (state_q == IDLE) && en_q && bus.cmd_valid;
   assign shift_go   = (state_q == SHIFT);
   assign cap_go     = (state_q == CAPTURE) && (cnt_q < CNT_W'(DATA_W));
   assign wdata_load = (bus.cmd_rw == RW_WRITE) ? bus.cmd_wdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rw_q    <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         en_q    <= 1'b1;
         if (accept) rw_q <= bus.cmd_rw;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = START;
         START:   state_d = SHIFT;
         SHIFT:   if (cnt_q == CNT_W'(SHIFT_LEN - 1))
                     state_d = (rw_q == RW_WRITE) ? WAIT_WR : WAIT_RD;
         WAIT_WR: if (cnt_q == CNT_W'(WR_WAIT - 1)) state_d = RESP;
         WAIT_RD: if (cnt_q == CNT_W'(RD_LAT - 1)) state_d = CAPTURE;
         CAPTURE: if (cnt_q == CNT_W'(CAP_LEN - 1)) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cnt_d = cnt_q + 1'b1;
      if ((state_d != state_q) || (state_q == IDLE) || (state_q == RESP)) cnt_d = '0;
   end

   mram_link_shifter #(.W(ADDR_W)) u_addr_sh (
      .clk(clk), .rst(rst), .load_i(accept), .load_data_i(bus.cmd_addr),
      .shift_i(shift_go), .ser_i(1'b0), .ser_o(addr_bit), .par_o(addr_par_unused)
   );

   // Zeros shift in behind the data word, giving the trailing zero bits of the frame for free.
   mram_link_shifter #(.W(DATA_W)) u_wdata_sh (
      .clk(clk), .rst(rst), .load_i(accept), .load_data_i(wdata_load),
      .shift_i(shift_go), .ser_i(1'b0), .ser_o(wdata_bit), .par_o(wdata_par_unused)
   );

   mram_link_shifter #(.W(DATA_W)) u_rdata_sh (
      .clk(clk), .rst(rst), .load_i(accept), .load_data_i('0),
      .shift_i(cap_go), .ser_i(bus.ser_data_in), .ser_o(rdata_msb_unused), .par_o(rdata)
   );

`ifdef MRAM_HOST_PARITY_EN
   logic par_q;
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_q <= 1'b0;
         err_q <= 1'b0;
      end else if (accept) begin
         par_q <= ^{bus.cmd_addr, wdata_load};
         err_q <= 1'b0;
      end else if ((state_q == CAPTURE) && (cnt_q == CNT_W'(DATA_W))) begin
         err_q <= bus.ser_data_in ^ (^rdata);
      end
   end

   assign bus.addr_ser = shift_go && ((cnt_q == CNT_W'(ADDR_W)) ? par_q : addr_bit);
   assign bus.rsp_err  = (state_q == RESP) && err_q;
`else
   assign bus.addr_ser = shift_go && addr_bit;
   assign bus.rsp_err  = 1'b0;
`endif

   assign bus.data_ser   = shift_go && wdata_bit;
   assign bus.cmd_ready  = (state_q == IDLE) && en_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.link_start = (state_q == START);
   assign bus.rw_sel     = (state_q != IDLE) && rw_q;
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_rdata  = (state_q == RESP) ? rdata : '0;
endmodule
